// File: rtl/systolic_feeder_if.sv
// Feeder bus: activation row handshake, weight load and the skewed X / W outputs
// toward the systolic array. Master drives rows/weights, slave is the feeder.
interface systolic_feeder_if #(
   parameter int N          = 3,
   parameter int K          = 4,
   parameter int DATA_WIDTH = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic [DATA_WIDTH*N-1:0]      in_data;
   logic                         w_load;
   logic [DATA_WIDTH*N*K-1:0]    w_in;
   logic [DATA_WIDTH*N-1:0]      X;
   logic [DATA_WIDTH*N*K-1:0]    W;
   logic                         x_valid;
   logic                         done;

   modport master (
      output in_valid, in_data, w_load, w_in,
      input  in_ready, X, W, x_valid, done
   );

   modport slave (
      input  in_valid, in_data, w_load, w_in,
      output in_ready, X, W, x_valid, done
   );
endinterface

// File: rtl/systolic_feeder.sv
// Systolic array input stage: buffers an M x N activation matrix and streams it
// diagonally skewed onto X. Define FEEDER_DOUBLE_BUF_EN for ping/pong row buffers.
module systolic_feeder_lane #(
   parameter int M          = 5,
   parameter int DATA_WIDTH = 8,
   parameter int TW         = 3,
   parameter int LANE       = 0
) (
   input  logic [TW-1:0]                t,
   input  logic [M-1:0][DATA_WIDTH-1:0] col,
   output logic [DATA_WIDTH-1:0]        x
);
   // Lane n shows row t-n; outside the matrix the lane carries zero.
   always_comb begin
      x = '0;
      for (int r = 0; r < M; r++)
         if (int'(t) == r + LANE) x = col[r];
   end
endmodule

module systolic_feeder #(
   parameter int M          = 5,
   parameter int N          = 3,
   parameter int K          = 4,
   parameter int DATA_WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   systolic_feeder_if.slave bus
);
   localparam int RW = (M > 1) ? $clog2(M) : 1;
   localparam int TW = (M + N - 1 > 1) ? $clog2(M + N - 1) : 1;

   typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

   state_t                              state_q, state_d;
   logic [RW-1:0]                       row_cnt_q;
   logic [TW-1:0]                       t_q, t_d;
   logic [N-1:0][DATA_WIDTH-1:0]        row_in, x_q, x_d, lane_x;
   logic [N-1:0][M-1:0][DATA_WIDTH-1:0] cols;
   logic [M-1:0][N-1:0][DATA_WIDTH-1:0] sbuf;
   logic [DATA_WIDTH*N*K-1:0]           w_q;
   logic                                xv_q, xv_d, done_q, done_d;
   logic                                in_ready, beat, last_row;

`ifdef FEEDER_DOUBLE_BUF_EN
   logic [1:0][M-1:0][N-1:0][DATA_WIDTH-1:0] rows_q;
   logic [1:0] full_q, full_d;
   logic       lb_q, lb_d, sb_q, sb_d;   // bank being loaded / bank being streamed
   assign in_ready = !full_q[lb_q];
   assign sbuf     = rows_q[sb_q];
`else
   logic [M-1:0][N-1:0][DATA_WIDTH-1:0] rows_q;
   assign in_ready = (state_q == LOAD);
   assign sbuf     = rows_q;
`endif

   assign row_in   = bus.in_data;
   assign beat     = bus.in_valid && in_ready;
   assign last_row = beat && (row_cnt_q == RW'(M - 1));

   for (genvar n = 0; n < N; n++) begin : g_lane
      for (genvar r = 0; r < M; r++) begin : g_col
         assign cols[n][r] = sbuf[r][n];
      end
      systolic_feeder_lane #(.M(M), .DATA_WIDTH(DATA_WIDTH), .TW(TW), .LANE(n)) u_lane (
         .t   (t_q),
         .col (cols[n]),
         .x   (lane_x[n])
      );
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      x_d     = '0;
      xv_d    = 1'b0;
      done_d  = 1'b0;
`ifdef FEEDER_DOUBLE_BUF_EN
      lb_d   = lb_q;
      sb_d   = sb_q;
      full_d = full_q;
      if (last_row) begin
         full_d[lb_q] = 1'b1;
         lb_d         = ~lb_q;
      end
`endif
      case (state_q)
         LOAD: if (last_row) begin
            state_d = STREAM;
            t_d     = '0;
`ifdef FEEDER_DOUBLE_BUF_EN
            sb_d    = lb_q;
`endif
         end
         STREAM: begin
            x_d  = lane_x;
            xv_d = 1'b1;
            t_d  = t_q + 1'b1;
            if (t_q == TW'(M + N - 2)) begin
               state_d = DONE;
               t_d     = '0;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = LOAD;
`ifdef FEEDER_DOUBLE_BUF_EN
            // A bank completed on this very edge still counts as ready to stream.
            full_d[sb_q] = 1'b0;
            if (full_d[~sb_q]) begin
               state_d = STREAM;
               sb_d    = ~sb_q;
            end
`endif
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= LOAD;
         row_cnt_q <= '0;
         t_q       <= '0;
         x_q       <= '0;
         xv_q      <= 1'b0;
         done_q    <= 1'b0;
         w_q       <= '0;
`ifdef FEEDER_DOUBLE_BUF_EN
         lb_q      <= 1'b0;
         sb_q      <= 1'b0;
         full_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         x_q     <= x_d;
         xv_q    <= xv_d;
         done_q  <= done_d;
         if (beat) row_cnt_q <= last_row ? '0 : row_cnt_q + 1'b1;
         if (bus.w_load && state_q == LOAD) w_q <= bus.w_in;
`ifdef FEEDER_DOUBLE_BUF_EN
         lb_q    <= lb_d;
         sb_q    <= sb_d;
         full_q  <= full_d;
`endif
      end
   end

   // Row storage carries no reset; contents are only read after a full load.
   always_ff @(posedge clk) begin
`ifdef FEEDER_DOUBLE_BUF_EN
      if (beat) rows_q[lb_q][row_cnt_q] <= row_in;
`else
      if (beat) rows_q[row_cnt_q] <= row_in;
`endif
   end

   assign bus.in_ready = in_ready;
   assign bus.X        = x_q;
   assign bus.W        = w_q;
   assign bus.x_valid  = xv_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: timeline model of expected X/x_valid/done/in_ready/W
// built from the skew rule, checked every cycle, plus hand-computed literals.
`timescale 1ns/1ps
module tb_systolic_feeder;
   localparam int M = 5, N = 3, K = 4, DW = 8;
   localparam int NBEAT = M + N - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_feeder_if #(.N(N), .K(K), .DATA_WIDTH(DW)) bus ();
   systolic_feeder #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic            xv;
      logic            dn;
      logic            rdy;
      logic            ld;
      logic [N*DW-1:0] x;
   } exp_t;

   exp_t            q[$];
   exp_t            cur;
   bit              waiting;
   int              ridx;
   int              acc[M][N];
   int              wmat[M][N];
   int              smat[M][N];
   logic [N*DW*K-1:0] w_exp;
   int              checks = 0;
   int              failures = 0;

   logic [N*DW-1:0] cap[0:15];
   int              capn, gapk;
   logic            cap_done;

   function automatic exp_t mk(input logic xv, input logic dn, input logic rdy,
                               input logic ld, input logic [N*DW-1:0] x);
      exp_t e;
      e.xv = xv; e.dn = dn; e.rdy = rdy; e.ld = ld; e.x = x;
      return e;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected timeline of one matrix: optional entry cycle, M+N-1 skewed beats, done.
   task automatic push_stream(input bit lead);
      logic [N*DW-1:0] xb;
      if (lead) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
      for (int b = 0; b < NBEAT; b++) begin
         xb = '0;
         for (int n = 0; n < N; n++)
            if (b - n >= 0 && b - n < M) xb[n*DW +: DW] = DW'(smat[b-n][n]);
         q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, xb));
      end
      q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, '0));
   endtask

   initial begin
      cur = mk(1'b0, 1'b0, 1'b1, 1'b1, '0);
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            q.delete();
            cur     = mk(1'b0, 1'b0, 1'b1, 1'b1, '0);
            waiting = 1'b0;
            ridx    = 0;
            w_exp   = '0;
         end else begin
            bit rdy_now;
`ifdef FEEDER_DOUBLE_BUF_EN
            rdy_now = !waiting;
`else
            rdy_now = cur.rdy;
`endif
            if (bus.w_load && cur.ld) w_exp = bus.w_in;
            if (bus.in_valid && rdy_now) begin
               for (int n = 0; n < N; n++) acc[ridx][n] = int'(bus.in_data[n*DW +: DW]);
               ridx++;
               if (ridx == M) begin
                  ridx = 0;
                  if (cur.ld) begin
                     smat = acc;
                     push_stream(1'b1);
                  end else begin
                     wmat    = acc;
                     waiting = 1'b1;
                  end
               end
            end
            cur = (q.size() > 0) ? q.pop_front() : mk(1'b0, 1'b0, 1'b1, 1'b1, '0);
            if (cur.dn && waiting) begin
               cur.ld  = 1'b0;
               smat    = wmat;
               push_stream(1'b0);
               waiting = 1'b0;
            end
         end
      end
   end

   initial begin
      logic exp_rdy;
      forever begin
         @(negedge clk);
         if (rst) begin
`ifdef FEEDER_DOUBLE_BUF_EN
            exp_rdy = !waiting;
`else
            exp_rdy = cur.rdy;
`endif
            check("x_valid", 128'(bus.x_valid), 128'(cur.xv));
            check("done", 128'(bus.done), 128'(cur.dn));
            check("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
            check("X", 128'(bus.X), 128'(cur.x));
            check("W", 128'(bus.W), 128'(w_exp));
         end
      end
   end

   function automatic logic [N*DW-1:0] row_of(input int off, input int r);
      logic [N*DW-1:0] v;
      for (int n = 0; n < N; n++) v[n*DW +: DW] = DW'(off + 10*r + n + 1);
      return v;
   endfunction

   task automatic send_row(input logic [N*DW-1:0] d);
      int k;
      k = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k == 100) check("row_accept_timeout", 128'(k), 128'(0));
      @(negedge clk);
   endtask

   task automatic send_matrix(input int off, input int gap);
      for (int r = 0; r < M; r++) begin
         send_row(row_of(off, r));
         if (gap > 0 && r == 1) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic grab_stream();
      int k;
      k = 0; capn = 0; cap_done = 1'b0;
      while (!bus.x_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      gapk = k;
      if (k == 50) check("stream_start_timeout", 128'(k), 128'(0));
      while (bus.x_valid && capn < 16) begin
         cap[capn] = bus.X;
         capn++;
         @(negedge clk);
      end
      cap_done = bus.done;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!bus.done && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) check("done_timeout", 128'(k), 128'(0));
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.w_load   = 1'b0;
      bus.w_in     = '0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_x_valid", 128'(bus.x_valid), 128'(0));
      check("rst_done", 128'(bus.done), 128'(0));
      check("rst_X", 128'(bus.X), 128'(0));
      check("rst_W", 128'(bus.W), 128'(0));
      rst = 1'b1;
      @(negedge clk);
      check("rdy_after_rst", 128'(bus.in_ready), 128'(1));

      // weights latched in LOAD
      bus.w_load = 1'b1;
      bus.w_in   = {(N*K){8'hA5}};
      @(negedge clk);
      bus.w_load = 1'b0;
      check("w_a5", 128'(bus.W), 128'({(N*K){8'hA5}}));

      // back-to-back load
      send_matrix(0, 0);
`ifdef FEEDER_DOUBLE_BUF_EN
      check("rdy_in_stream", 128'(bus.in_ready), 128'(1));
`else
      check("rdy_in_stream", 128'(bus.in_ready), 128'(0));
`endif
      grab_stream();
      check("t1_beats", 128'(capn), 128'(7));
      check("t1_beat0", 128'(cap[0]), 128'(24'h000001));
      check("t1_beat1", 128'(cap[1]), 128'(24'h00020B));
      check("t1_beat2", 128'(cap[2]), 128'(24'h030C15));
      check("t1_beat3", 128'(cap[3]), 128'(24'h0D161F));
      check("t1_beat6", 128'(cap[6]), 128'(24'h2B0000));
      check("t1_done", 128'(cap_done), 128'(1));
      @(negedge clk);

      // gapped load, then a w_load of zero while streaming must be ignored
      send_matrix(0, 3);
      bus.w_load = 1'b1;
      bus.w_in   = '0;
      @(negedge clk);
      bus.w_load = 1'b0;
      wait_done();
      check("w_hold", 128'(bus.W), 128'({(N*K){8'hA5}}));

`ifndef FEEDER_DOUBLE_BUF_EN
      // in_valid held through STREAM: next matrix waits for done
      send_matrix(0, 0);
      check("t3_rdy_low", 128'(bus.in_ready), 128'(0));
      send_matrix(50, 0);
      grab_stream();
      check("t3_beats", 128'(capn), 128'(7));
      check("t3_beat0", 128'(cap[0]), 128'(24'h000033));
      check("t3_beat6", 128'(cap[6]), 128'(24'h5D0000));
      @(negedge clk);
`endif

      // reset at beat 3 aborts the stream
      send_matrix(0, 0);
      grab_stream_prefix();
      #2 rst = 1'b0;
      #1;
      check("arst_X", 128'(bus.X), 128'(0));
      check("arst_x_valid", 128'(bus.x_valid), 128'(0));
      check("arst_done", 128'(bus.done), 128'(0));
      repeat (2) @(negedge clk);
      check("arst_no_done", 128'(bus.done), 128'(0));
      rst = 1'b1;
      #1;
      check("arst_rdy", 128'(bus.in_ready), 128'(1));
      @(negedge clk);
      send_matrix(0, 0);
      grab_stream();
      check("t4_beats", 128'(capn), 128'(7));
      check("t4_beat6", 128'(cap[6]), 128'(24'h2B0000));
      check("t4_done", 128'(cap_done), 128'(1));
      @(negedge clk);

`ifdef FEEDER_DOUBLE_BUF_EN
      // matrix B loads during A's stream and follows after a single gap cycle
      send_matrix(0, 0);
      fork
         send_matrix(100, 0);
         grab_stream();
      join
      check("t5_a_beats", 128'(capn), 128'(7));
      check("t5_a_done", 128'(cap_done), 128'(1));
      grab_stream();
      check("t5_gap", 128'(gapk), 128'(1));
      check("t5_b_beats", 128'(capn), 128'(7));
      check("t5_b_beat0", 128'(cap[0]), 128'(24'h000065));
      check("t5_b_beat6", 128'(cap[6]), 128'(24'h8F0000));
      @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Waits for the first beat, then advances to the beat-3 cycle.
   task automatic grab_stream_prefix();
      int k;
      k = 0;
      while (!bus.x_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) check("prefix_timeout", 128'(k), 128'(0));
      repeat (3) @(negedge clk);
      check("prefix_beat3", 128'(bus.X), 128'(24'h0D161F));
   endtask
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream input stage for the M/N/K systolic array.
- Accepts an M x N activation matrix one row per handshake beat and buffers it.
- Latches a stationary N x K weight block.
- Streams the activations into the array's X bus with diagonal skew, so lane n is delayed n cycles relative to lane 0.
- Flags start/end of the stream for the downstream result collector.

Parameters:
M, 5, rows of the activation matrix (stream length driver)
N, 3, array input lanes / elements per row
K, 4, array output columns (weight bus sizing only)
DATA_WIDTH, 8, bits per element

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  row beat valid
in_ready  output  1  feeder can accept a row
in_data  input  DATA_WIDTH*N  one activation row; element n at bits [n*DATA_WIDTH +: DATA_WIDTH]
w_load  input  1  latch w_in this cycle
w_in  input  DATA_WIDTH*N*K  weight block
X  output  DATA_WIDTH*N  skewed activations to array, same lane layout
W  output  DATA_WIDTH*N*K  registered weights to array
x_valid  output  1  X carries a stream beat
done  output  1  one-cycle pulse after last beat

Behaviour:
- Reset (rst=0, async): state=LOAD; row counter=0; beat counter=0.
- Reset values: X=0, W=0, x_valid=0, done=0, in_ready=1 (once reset is released).
- Buffer contents need not be cleared.
- Reset mid-stream aborts immediately; no done pulse.
- States:
  - LOAD: in_ready=1. A beat (in_valid & in_ready) writes in_data to buffer row[row_cnt] and increments row_cnt. On the beat with row_cnt==M-1, go to STREAM with t=0 and row_cnt=0. in_valid outside LOAD is ignored.
  - STREAM: in_ready=0. Each edge registers X lane n <= buf[t-n][n] if 0 <= t-n <= M-1, else 0, sets x_valid<=1 and increments t. On the edge with t==M+N-2, go to DONE.
  - DONE: one edge sets X<=0, x_valid<=0, done<=1, then returns to LOAD. The next edge clears done.
- Result: x_valid is high for exactly M+N-1 consecutive cycles, starting the cycle after the M-th row is accepted. done is high for the first cycle in which x_valid is low.
- No backpressure from the array; the stream is never stalled.
- Weights: w_load is honoured only in LOAD, with W<=w_in on that edge. In other states it is ignored, so W is stable for the whole stream. A w_load on the same edge as the final row beat is honoured.
- Counters: row_cnt is clog2(M) bits; t is clog2(M+N-1) bits. Both wrap to 0 as described, never past their maxima.
- Arithmetic: no arithmetic on data; elements pass through unmodified.

Optional Feature:
FEEDER_DOUBLE_BUF_EN
- Defined:
  - Two row buffers (ping/pong). in_ready=1 in every state while the non-streaming bank is not full, so the next matrix loads during STREAM/DONE.
  - On leaving DONE, if the other bank is full, enter STREAM on that bank directly. X then resumes one cycle after done, with a single x_valid=0 gap cycle.
  - If the other bank is not full, return to LOAD.
  - w_load is still honoured only in LOAD.
- Undefined: single buffer, behaviour exactly as above; in_ready=0 in STREAM and DONE.

Test Plan:
Defaults M=5, N=3, DATA_WIDTH=8. Row r = {X[r][2],X[r][1],X[r][0]} with X[r][n]=10r+n+1.
- Load 5 rows back-to-back -> x_valid high 7 cycles. Beat0 lanes(0,1,2)=(1,0,0); beat1=(11,2,0); beat2=(21,12,3); beat6=(0,0,43). done=1 in the cycle after beat6.
- Load rows with in_valid gaps (idle cycles between rows 1 and 2) -> same 7-beat sequence, starting the cycle after row 4 is accepted.
- w_load with w_in=0xA5 repeated during LOAD -> W=0xA5..; w_load with 0x00 during STREAM -> W unchanged, stream unaffected.
- in_valid=1 held throughout STREAM without macro -> in_ready=0, no row captured, next matrix starts loading only after done.
- Assert rst=0 at beat 3 -> X=0, x_valid=0 asynchronously, no done. After release, in_ready=1 and a fresh load streams correctly.
- With FEEDER_DOUBLE_BUF_EN: load matrix B during matrix A's stream -> A's 7 beats, done, one gap cycle, then B's 7 beats with correct skew.
